jisuan_keystream_ctrl: RTL



---
 rtl/jisuan_keystream_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/jisuan_keystream_ctrl.sv
// jisuan_keystream_ctrl: builds ChaCha20/Salsa20 initial states for a shared
// double-round core, streams them in, and applies the feedforward addition
// to produce consecutive 512-bit keystream blocks for both ciphers.
module jisuan_keystream_ctrl #(
    parameter int unsigned NBLK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [255:0]      req_key,
    input  logic [63:0]       req_nonce,
    input  logic [63:0]       req_ctr,
    input  logic [NBLK_W-1:0] req_nblk,
    output logic              core_in_vld,
    input  logic              core_in_rdy,
    output logic [511:0]      core_x_cha,
    output logic [511:0]      core_x_sha,
    input  logic              core_out_vld,
    output logic              core_out_rdy,
    input  logic [511:0]      core_r_cha,
    input  logic [511:0]      core_r_sha,
    output logic              ks_vld,
    input  logic              ks_rdy,
    output logic [511:0]      ks_cha,
    output logic [511:0]      ks_sha,
    output logic              ks_last
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NWORD  = 16;
    localparam int unsigned REM_W  = NBLK_W + 1;

    localparam logic [WORD_W-1:0] C0 = 32'h6170_7865;
    localparam logic [WORD_W-1:0] C1 = 32'h3320_646e;
    localparam logic [WORD_W-1:0] C2 = 32'h7962_2d32;
    localparam logic [WORD_W-1:0] C3 = 32'h6b20_6574;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [255:0]       key_r;
    logic [63:0]        nonce_r;
    logic [63:0]        ctr_r;
    logic [REM_W-1:0]   rem_r;
    logic [511:0]       ks_cha_nxt;
    logic [511:0]       ks_sha_nxt;
    logic               req_hs;
    logic               out_hs;
    logic               ks_hs;

    assign req_hs = req_vld & req_rdy;
    assign out_hs = core_out_vld & core_out_rdy;
    assign ks_hs  = ks_vld & ks_rdy;

    // Initial states for both ciphers from the captured request and current counter
    always_comb begin
        core_x_cha = '0;
        core_x_sha = '0;
        core_x_cha[0*WORD_W +: WORD_W]  = C0;
        core_x_cha[1*WORD_W +: WORD_W]  = C1;
        core_x_cha[2*WORD_W +: WORD_W]  = C2;
        core_x_cha[3*WORD_W +: WORD_W]  = C3;
        for (int k = 0; k < 8; k++) begin
            core_x_cha[WORD_W*(4+k) +: WORD_W] = key_r[WORD_W*k +: WORD_W];
        end
        core_x_cha[12*WORD_W +: WORD_W] = ctr_r[31:0];
        core_x_cha[13*WORD_W +: WORD_W] = ctr_r[63:32];
        core_x_cha[14*WORD_W +: WORD_W] = nonce_r[31:0];
        core_x_cha[15*WORD_W +: WORD_W] = nonce_r[63:32];

        core_x_sha[0*WORD_W +: WORD_W]  = C0;
        core_x_sha[5*WORD_W +: WORD_W]  = C1;
        core_x_sha[10*WORD_W +: WORD_W] = C2;
        core_x_sha[15*WORD_W +: WORD_W] = C3;
        for (int k = 0; k < 4; k++) begin
            core_x_sha[WORD_W*(1+k) +: WORD_W]  = key_r[WORD_W*k +: WORD_W];
            core_x_sha[WORD_W*(11+k) +: WORD_W] = key_r[WORD_W*(4+k) +: WORD_W];
        end
        core_x_sha[6*WORD_W +: WORD_W]  = nonce_r[31:0];
        core_x_sha[7*WORD_W +: WORD_W]  = nonce_r[63:32];
        core_x_sha[8*WORD_W +: WORD_W]  = ctr_r[31:0];
        core_x_sha[9*WORD_W +: WORD_W]  = ctr_r[63:32];
    end

    // Feedforward: per-word modular add of permuted and initial state
    always_comb begin
        ks_cha_nxt = '0;
        ks_sha_nxt = '0;
        for (int i = 0; i < NWORD; i++) begin
            ks_cha_nxt[WORD_W*i +: WORD_W] = core_r_cha[WORD_W*i +: WORD_W] + core_x_cha[WORD_W*i +: WORD_W];
            ks_sha_nxt[WORD_W*i +: WORD_W] = core_r_sha[WORD_W*i +: WORD_W] + core_x_sha[WORD_W*i +: WORD_W];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nxt    = state;
        req_rdy      = 1'b0;
        core_in_vld  = 1'b0;
        core_out_rdy = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                core_in_vld = 1'b1;
                if (core_in_rdy) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                core_out_rdy = ~ks_vld | ks_rdy;
                if (core_out_vld & core_out_rdy) begin
                    state_nxt = (rem_r > REM_W'(1)) ? ISSUE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Block counter and remaining-block count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_r <= '0;
            rem_r <= '0;
        end else if (req_hs) begin
            ctr_r <= req_ctr;
            rem_r <= (req_nblk == '0) ? {1'b1, {NBLK_W{1'b0}}} : REM_W'(req_nblk);
        end else if (out_hs) begin
            ctr_r <= ctr_r + 64'd1;
            rem_r <= rem_r - REM_W'(1);
        end
    end

    // Key and nonce capture
    always_ff @(posedge clk) begin
        if (req_hs) begin
            key_r   <= req_key;
            nonce_r <= req_nonce;
        end
    end

    // Output slot flags; a reload wins over a drain in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks_vld  <= 1'b0;
            ks_last <= 1'b0;
        end else if (out_hs) begin
            ks_vld  <= 1'b1;
            ks_last <= (rem_r == REM_W'(1));
        end else if (ks_hs) begin
            ks_vld  <= 1'b0;
            ks_last <= 1'b0;
        end
    end

    // Output slot data
    always_ff @(posedge clk) begin
        if (out_hs) begin
            ks_cha <= ks_cha_nxt;
            ks_sha <= ks_sha_nxt;
        end
    end

endmodule
